multi_one_shot: RTL and testbench

//  N-channel one-shot pulse generator. It turns level requests (buttons, start strobes

---
 rtl/multi_one_shot.sv | 122 ++++++++++++
 tb/tb_multi_one_shot.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_one_shot.sv
// multi_one_shot: N-channel one-shot pulse generator.
// Each channel synchronises its start level, qualifies it with enable, and
// emits one PULSE_W-cycle shot per request assertion. Optional retrigger
// extends a running pulse on a fresh request edge.
module multi_one_shot #(
    parameter int N_CH        = 4,
    parameter int PULSE_W     = 1,
    parameter int SYNC_STAGES = 2,
    parameter bit ACTIVE_LOW  = 1'b0,
    parameter bit RETRIG      = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [N_CH-1:0] start,
    output logic [N_CH-1:0] shot,
    output logic [N_CH-1:0] busy,
    output logic            any_shot
);

    localparam int              CW         = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [CW-1:0]   CNT_LOAD   = CW'(PULSE_W - 1);
    localparam logic [N_CH-1:0] START_IDLE = {N_CH{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        HOLD  = 2'b10
    } state_t;

    logic [N_CH-1:0] start_s;   // start after the synchroniser chain
    logic [N_CH-1:0] act;       // request, polarity-normalised (1 = request)
    logic [N_CH-1:0] act_q;     // act one cycle ago, for retrigger edge detect

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign start_s = start;
        end else begin : g_sync
            logic [N_CH-1:0] sync_r [SYNC_STAGES];

            // Shift the raw start levels through the synchroniser chain.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    // NOTE: the chain resets to the inactive start level, not to 0,
                    // so an active-low channel does not see a request at reset exit.
                    for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= START_IDLE;
                end else begin
                    // NOTE: non-blocking assignments make each stage take the previous
                    // stage's old value, giving a true multi-flop delay line.
                    sync_r[0] <= start;
                    for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
                end
            end

            assign start_s = sync_r[SYNC_STAGES-1];
        end
    endgenerate

    assign act = start_s ^ START_IDLE;

    // Remember the previous request level for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) act_q <= '0;
        else        act_q <= act;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t        state, state_nxt;
        logic [CW-1:0] cnt, cnt_nxt;

        // Channel state and width counter registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // Next-state logic: fire from IDLE, count down in PULSE, wait out the request in HOLD.
        always_comb begin
            // NOTE: every output of this block gets a default first so no path
            // leaves a signal unassigned and no latch is inferred.
            state_nxt = IDLE;
            cnt_nxt   = cnt;
            case (state)
                IDLE: begin
                    if (enable && act[i]) begin
                        state_nxt = PULSE;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
                PULSE: begin
                    if (RETRIG && act[i] && !act_q[i]) begin
                        state_nxt = PULSE;
                        cnt_nxt   = CNT_LOAD;
                    end else if (cnt == '0) begin
                        state_nxt = act[i] ? HOLD : IDLE;
                    end else begin
                        state_nxt = PULSE;
                        cnt_nxt   = cnt - CW'(1);
                    end
                end
                HOLD: begin
                    state_nxt = act[i] ? HOLD : IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign shot[i] = (state == PULSE);
        assign busy[i] = (state != IDLE);
    end

    assign any_shot = |shot;

endmodule

// File: tb/tb_multi_one_shot.sv
// Testbench for multi_one_shot: seven instances, each with the parameter set
// of one scenario, driven by a directed sequence. Expected outputs are pushed
// into a scoreboard queue as stimulus is applied and compared after each edge.
module tb_multi_one_shot;

    localparam int NU = 7;

    logic clk;
    logic reset;
    logic [NU-1:0]      en_i;
    logic [NU-1:0][3:0] start_i;
    logic [NU-1:0][3:0] shot_o;
    logic [NU-1:0][3:0] busy_o;
    logic [NU-1:0]      any_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    typedef struct {
        string      tag;
        int         unit;
        logic [3:0] shot;
        logic [3:0] busy;
    } exp_t;

    exp_t sb_q[$];

    // 0: defaults
    multi_one_shot u_def (.clk(clk), .reset(reset), .enable(en_i[0]), .start(start_i[0]),
                          .shot(shot_o[0]), .busy(busy_o[0]), .any_shot(any_o[0]));
    // 1: 5-cycle pulse, no synchroniser
    multi_one_shot #(.PULSE_W(5), .SYNC_STAGES(0)) u_w5 (
        .clk(clk), .reset(reset), .enable(en_i[1]), .start(start_i[1]),
        .shot(shot_o[1]), .busy(busy_o[1]), .any_shot(any_o[1]));
    // 2: 4-cycle pulse with retrigger
    multi_one_shot #(.PULSE_W(4), .SYNC_STAGES(0), .RETRIG(1'b1)) u_rt (
        .clk(clk), .reset(reset), .enable(en_i[2]), .start(start_i[2]),
        .shot(shot_o[2]), .busy(busy_o[2]), .any_shot(any_o[2]));
    // 3: 4-cycle pulse without retrigger
    multi_one_shot #(.PULSE_W(4), .SYNC_STAGES(0), .RETRIG(1'b0)) u_nr (
        .clk(clk), .reset(reset), .enable(en_i[3]), .start(start_i[3]),
        .shot(shot_o[3]), .busy(busy_o[3]), .any_shot(any_o[3]));
    // 4: enable gating, 3-cycle pulse
    multi_one_shot #(.PULSE_W(3), .SYNC_STAGES(0)) u_en (
        .clk(clk), .reset(reset), .enable(en_i[4]), .start(start_i[4]),
        .shot(shot_o[4]), .busy(busy_o[4]), .any_shot(any_o[4]));
    // 5: active-low requests
    multi_one_shot #(.ACTIVE_LOW(1'b1)) u_al (
        .clk(clk), .reset(reset), .enable(en_i[5]), .start(start_i[5]),
        .shot(shot_o[5]), .busy(busy_o[5]), .any_shot(any_o[5]));
    // 6: 8-cycle pulse for mid-pulse reset
    multi_one_shot #(.PULSE_W(8), .SYNC_STAGES(0)) u_w8 (
        .clk(clk), .reset(reset), .enable(en_i[6]), .start(start_i[6]),
        .shot(shot_o[6]), .busy(busy_o[6]), .any_shot(any_o[6]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int unit,
                              input logic [3:0] s, input logic [3:0] b);
        exp_t e;
        e.tag  = tag;
        e.unit = unit;
        e.shot = s;
        e.busy = b;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".shot"}, shot_o[e.unit], e.shot);
            check({e.tag, ".busy"}, busy_o[e.unit], e.busy);
            check({e.tag, ".any"}, {3'b000, any_o[e.unit]}, {3'b000, |e.shot});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        en_i       = '1;
        en_i[4]    = 1'b0;
        start_i    = '0;
        start_i[5] = 4'hF;

        // Reset state of every instance.
        #2;
        for (int u = 0; u < NU; u++) expect_out($sformatf("rst u%0d", u), u, 4'h0, 4'h0);
        drain();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Scenario 1 (defaults) plus active-low unit staying quiet after reset exit.
        start_i[0][0] = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            expect_out($sformatf("t1 n%0d", n), 0, (n == 3) ? 4'h1 : 4'h0, (n >= 3) ? 4'h1 : 4'h0);
            expect_out($sformatf("t5rst n%0d", n), 5, 4'h0, 4'h0);
            tick();
        end
        start_i[0][0] = 1'b0;
        for (int n = 11; n <= 14; n++) begin
            expect_out($sformatf("t1 n%0d", n), 0, 4'h0, (n <= 12) ? 4'h1 : 4'h0);
            tick();
        end

        // Scenario 5: all active-low channels requested on the same edge.
        start_i[5] = 4'h0;
        expect_out("t5 n1", 5, 4'h0, 4'h0); tick();
        expect_out("t5 n2", 5, 4'h0, 4'h0); tick();
        expect_out("t5 n3", 5, 4'hF, 4'hF); tick();
        expect_out("t5 n4", 5, 4'h0, 4'hF); tick();
        start_i[5] = 4'hF;
        expect_out("t5 n5", 5, 4'h0, 4'hF); tick();
        expect_out("t5 n6", 5, 4'h0, 4'hF); tick();
        expect_out("t5 n7", 5, 4'h0, 4'h0); tick();

        // Scenario 2: one-cycle request gives a 5-cycle shot, twice.
        start_i[1][2] = 1'b1;
        expect_out("t2 n1", 1, 4'h4, 4'h4); tick();
        start_i[1][2] = 1'b0;
        for (int n = 2; n <= 5; n++) begin
            expect_out($sformatf("t2 n%0d", n), 1, 4'h4, 4'h4); tick();
        end
        expect_out("t2 n6", 1, 4'h0, 4'h0); tick();
        expect_out("t2 n7", 1, 4'h0, 4'h0); tick();
        start_i[1][2] = 1'b1;
        expect_out("t2 n8", 1, 4'h4, 4'h4); tick();
        start_i[1][2] = 1'b0;
        for (int n = 9; n <= 12; n++) begin
            expect_out($sformatf("t2 n%0d", n), 1, 4'h4, 4'h4); tick();
        end
        expect_out("t2 n13", 1, 4'h0, 4'h0); tick();

        // Scenario 3: request, drop, re-request in pulse cycle 3; retrig vs not.
        start_i[2][0] = 1'b1;
        start_i[3][0] = 1'b1;
        expect_out("t3r n1", 2, 4'h1, 4'h1);
        expect_out("t3n n1", 3, 4'h1, 4'h1);
        tick();
        start_i[2][0] = 1'b0;
        start_i[3][0] = 1'b0;
        expect_out("t3r n2", 2, 4'h1, 4'h1);
        expect_out("t3n n2", 3, 4'h1, 4'h1);
        tick();
        start_i[2][0] = 1'b1;
        start_i[3][0] = 1'b1;
        for (int n = 3; n <= 7; n++) begin
            expect_out($sformatf("t3r n%0d", n), 2, (n <= 6) ? 4'h1 : 4'h0, 4'h1);
            expect_out($sformatf("t3n n%0d", n), 3, (n <= 4) ? 4'h1 : 4'h0, 4'h1);
            tick();
        end
        start_i[2][0] = 1'b0;
        start_i[3][0] = 1'b0;
        expect_out("t3r n8", 2, 4'h0, 4'h0);
        expect_out("t3n n8", 3, 4'h0, 4'h0);
        tick();

        // Scenario 4: enable gating; dropping enable does not cut the pulse.
        start_i[4][1] = 1'b1;
        expect_out("t4 n1", 4, 4'h0, 4'h0); tick();
        expect_out("t4 n2", 4, 4'h0, 4'h0); tick();
        en_i[4] = 1'b1;
        expect_out("t4 n3", 4, 4'h2, 4'h2); tick();
        en_i[4] = 1'b0;
        expect_out("t4 n4", 4, 4'h2, 4'h2); tick();
        expect_out("t4 n5", 4, 4'h2, 4'h2); tick();
        expect_out("t4 n6", 4, 4'h0, 4'h2); tick();
        start_i[4][1] = 1'b0;
        expect_out("t4 n7", 4, 4'h0, 4'h0); tick();
        start_i[4][1] = 1'b1;
        expect_out("t4 n8", 4, 4'h0, 4'h0); tick();
        expect_out("t4 n9", 4, 4'h0, 4'h0); tick();

        // Scenario 6: asynchronous reset mid-pulse, then a fresh full pulse.
        start_i[6][3] = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            expect_out($sformatf("t6 n%0d", n), 6, 4'h8, 4'h8); tick();
        end
        #2;
        reset = 1'b0;
        #1;
        expect_out("t6 async", 6, 4'h0, 4'h0);
        drain();
        #2;
        reset = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            expect_out($sformatf("t6 post n%0d", n), 6, (n <= 8) ? 4'h8 : 4'h0, 4'h8);
            tick();
        end
        start_i[6][3] = 1'b0;
        expect_out("t6 post n10", 6, 4'h0, 4'h0); tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
